// File: rtl/regfile_wb_arbiter.sv
// Merges the ALU and LSU writeback streams onto the register file's single write port.
// Each requester has a circular FIFO, drained round-robin, with a pending-write bitmap for RAW stalls.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_WIDTH-1:0]      alu_addr,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [ADDR_WIDTH-1:0]      lsu_addr,
    input  logic [DATA_WIDTH-1:0]      lsu_data,
    output logic                       we3,
    output logic [ADDR_WIDTH-1:0]      ad3,
    output logic [DATA_WIDTH-1:0]      wd3,
    output logic [2**ADDR_WIDTH-1:0]   pending,
    output logic                       busy
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Requester index 0 is the ALU, index 1 the LSU.
    logic [ADDR_WIDTH-1:0] r_addr   [2][DEPTH];
    logic [DATA_WIDTH-1:0] r_data   [2][DEPTH];
    logic [DEPTH-1:0]      r_vld    [2];
    logic [PW-1:0]         r_wr_ptr [2];
    logic [PW-1:0]         r_rd_ptr [2];
    logic [CW-1:0]         r_count  [2];
    logic                  r_last_lsu;

    logic [1:0]            w_valid;
    logic [1:0]            w_ready;
    logic [1:0]            w_push;
    logic [1:0]            w_pop;
    logic [1:0]            w_ne;
    logic [ADDR_WIDTH-1:0] w_in_addr [2];
    logic [DATA_WIDTH-1:0] w_in_data [2];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_valid      = {lsu_valid, alu_valid};
    assign w_in_addr[0] = alu_addr;
    assign w_in_addr[1] = lsu_addr;
    assign w_in_data[0] = alu_data;
    assign w_in_data[1] = lsu_data;
    assign alu_ready    = w_ready[0];
    assign lsu_ready    = w_ready[1];
    assign busy         = |w_ne;

    always_comb begin
        w_ne    = '0;
        w_ready = '0;
        w_push  = '0;
        for (int f = 0; f < 2; f++) begin
            w_ne[f]    = (r_count[f] != '0);
            w_ready[f] = (r_count[f] < FULL_CNT);
            w_push[f]  = w_valid[f] && w_ready[f];
        end
        // On contention the requester not served last time wins.
        w_pop[0] = w_ne[0] && !(w_ne[1] && !r_last_lsu);
        w_pop[1] = w_ne[1] && !(w_ne[0] && r_last_lsu);
    end

    always_comb begin
        we3 = 1'b0;
        ad3 = '0;
        wd3 = '0;
        for (int f = 0; f < 2; f++) begin
            if (w_pop[f]) begin
                we3 = 1'b1;
                ad3 = r_addr[f][r_rd_ptr[f]];
                wd3 = r_data[f][r_rd_ptr[f]];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_vld[f][i]) begin
                    pending[r_addr[f][i]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < 2; f++) begin
                r_wr_ptr[f] <= '0;
                r_rd_ptr[f] <= '0;
                r_count[f]  <= '0;
                r_vld[f]    <= '0;
            end
            r_last_lsu <= 1'b1;
        end else begin
            for (int f = 0; f < 2; f++) begin
                // Push and pop never hit the same slot: push needs non-full, pop non-empty.
                if (w_push[f]) begin
                    r_wr_ptr[f]              <= next_ptr(r_wr_ptr[f]);
                    r_vld[f][r_wr_ptr[f]]    <= 1'b1;
                end
                if (w_pop[f]) begin
                    r_rd_ptr[f]              <= next_ptr(r_rd_ptr[f]);
                    r_vld[f][r_rd_ptr[f]]    <= 1'b0;
                end
                r_count[f] <= r_count[f] + CW'(w_push[f]) - CW'(w_pop[f]);
            end
            if (|w_pop) begin
                r_last_lsu <= w_pop[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < 2; f++) begin
            if (w_push[f]) begin
                r_addr[f][r_wr_ptr[f]] <= w_in_addr[f];
                r_data[f][r_wr_ptr[f]] <= w_in_data[f];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the two requesters.
module tb_regfile_wb_arbiter;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned NREG  = 32;
    localparam int          DEP_I = int'(DEPTH);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_addr = '0;
    logic [DW-1:0]   alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_addr = '0;
    logic [DW-1:0]   lsu_data = '0;
    logic            we3;
    logic [AW-1:0]   ad3;
    logic [DW-1:0]   wd3;
    logic [NREG-1:0] pending;
    logic            busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .we3       (we3),
        .ad3       (ad3),
        .wd3       (wd3),
        .pending   (pending),
        .busy      (busy)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq0[$];
    ent_t          mq1[$];
    int            m_last = 1;  // 0: ALU served last, 1: LSU served last
    int            total = 0;
    int            bad = 0;
    int            ncyc = 0;
    bit            acc0;
    bit            acc1;
    logic [DW-1:0] obs_d[$];
    int            obs_c[$];
    logic [DW-1:0] sent0[$];
    logic [DW-1:0] sent1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (mq0.size() == 0 && mq1.size() == 0) return -1;
        if (mq1.size() == 0) return 0;
        if (mq0.size() == 0) return 1;
        return 1 - m_last;
    endfunction

    task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_addr  = la;
        lsu_data  = ld;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int              g;
        logic [NREG-1:0] ep;
        ent_t            e;
        @(negedge clk);
        g  = model_grant();
        ep = '0;
        foreach (mq0[i]) ep[mq0[i].a] = 1'b1;
        foreach (mq1[i]) ep[mq1[i].a] = 1'b1;
        e = '0;
        if (g == 0) e = mq0[0];
        else if (g == 1) e = mq1[0];
        chk("we3", 64'(we3), 64'(g >= 0));
        chk("ad3", 64'(ad3), 64'(e.a));
        chk("wd3", 64'(wd3), 64'(e.d));
        chk("pending", 64'(pending), 64'(ep));
        chk("busy", 64'(busy), 64'((mq0.size() + mq1.size()) != 0));
        chk("alu_ready", 64'(alu_ready), 64'(mq0.size() < DEP_I));
        chk("lsu_ready", 64'(lsu_ready), 64'(mq1.size() < DEP_I));
        if (we3 === 1'b1) begin
            obs_d.push_back(wd3);
            obs_c.push_back(ncyc);
        end
        acc0 = alu_valid && (mq0.size() < DEP_I);
        acc1 = lsu_valid && (mq1.size() < DEP_I);
        @(posedge clk);
        if (g == 0) begin
            void'(mq0.pop_front());
            m_last = 0;
        end else if (g == 1) begin
            void'(mq1.pop_front());
            m_last = 1;
        end
        if (acc0) mq0.push_back('{a: alu_addr, d: alu_data});
        if (acc1) mq1.push_back('{a: lsu_addr, d: lsu_data});
        ncyc++;
        #1;
    endtask

    // Asynchronous reset asserted away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        mq0.delete();
        mq1.delete();
        m_last = 1;
        #1;
        chk("rst_we3", 64'(we3), 64'(0));
        chk("rst_ad3", 64'(ad3), 64'(0));
        chk("rst_wd3", 64'(wd3), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_alu_ready", 64'(alu_ready), 64'(1));
        chk("rst_lsu_ready", 64'(lsu_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer na ALU and nl LSU entries, holding valid until each is accepted, then drain.
    task automatic stream(input int na, input int nl);
        int            i0 = 0;
        int            i1 = 0;
        logic [AW-1:0] ca0 = AW'($urandom);
        logic [AW-1:0] ca1 = AW'($urandom);
        logic [DW-1:0] cd0 = $urandom;
        logic [DW-1:0] cd1 = $urandom;
        sent0.delete();
        sent1.delete();
        for (int c = 0; c < 80; c++) begin
            if (i0 >= na && i1 >= nl && mq0.size() == 0 && mq1.size() == 0) break;
            drive(i0 < na, ca0, cd0, i1 < nl, ca1, cd1);
            cycle();
            if (acc0) begin
                sent0.push_back(cd0);
                i0++;
                ca0 = AW'($urandom);
                cd0 = $urandom;
            end
            if (acc1) begin
                sent1.push_back(cd1);
                i1++;
                ca1 = AW'($urandom);
                cd1 = $urandom;
            end
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        int ws;
        do_reset();

        // Single ALU write: visible the cycle after the push, gone the cycle after that.
        drive(1'b1, AW'(3), 32'hDEADBEEF, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("t1_we3", 64'(we3), 64'(1));
        chk("t1_ad3", 64'(ad3), 64'(3));
        chk("t1_wd3", 64'(wd3), 64'(32'hDEADBEEF));
        chk("t1_pend3", 64'(pending[3]), 64'(1));
        cycle();
        chk("t1_we3_off", 64'(we3), 64'(0));
        chk("t1_pend_off", 64'(pending), 64'(0));
        chk("t1_busy_off", 64'(busy), 64'(0));

        // Same-edge pushes after reset: ALU wins first, two back-to-back writes.
        do_reset();
        drive(1'b1, AW'(5), 32'h11, 1'b1, AW'(6), 32'h22);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("t2_first_ad3", 64'(ad3), 64'(5));
        chk("t2_first_wd3", 64'(wd3), 64'(32'h11));
        cycle();
        chk("t2_second_we3", 64'(we3), 64'(1));
        chk("t2_second_ad3", 64'(ad3), 64'(6));
        chk("t2_second_wd3", 64'(wd3), 64'(32'h22));
        cycle();
        chk("t2_done_we3", 64'(we3), 64'(0));

        // Continuous traffic on both: strict alternation, 12 writes in 12 cycles.
        do_reset();
        ws = obs_d.size();
        stream(6, 6);
        chk("t3_nwrites", 64'(obs_d.size() - ws), 64'(12));
        if (obs_d.size() >= ws + 12 && sent0.size() == 6 && sent1.size() == 6) begin
            chk("t3_span", 64'(obs_c[ws + 11] - obs_c[ws] + 1), 64'(12));
            for (int k = 0; k < 6; k++) begin
                chk("t3_alu_order", 64'(obs_d[ws + 2 * k]), 64'(sent0[k]));
                chk("t3_lsu_order", 64'(obs_d[ws + 2 * k + 1]), 64'(sent1[k]));
            end
        end

        // LSU alone: order preserved across the pointer wrap.
        do_reset();
        ws = obs_d.size();
        stream(0, 3);
        chk("t4_nwrites", 64'(obs_d.size() - ws), 64'(3));
        if (obs_d.size() >= ws + 3 && sent1.size() == 3) begin
            for (int k = 0; k < 3; k++) chk("t4_order", 64'(obs_d[ws + k]), 64'(sent1[k]));
        end

        // Both requesters target r7: pending[7] holds until the second write pops.
        do_reset();
        drive(1'b1, AW'(7), 32'hA7, 1'b1, AW'(7), 32'hB7);
        cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("t5_p7_both", 64'(pending[7]), 64'(1));
        cycle();
        chk("t5_p7_one", 64'(pending[7]), 64'(1));
        cycle();
        chk("t5_p7_clear", 64'(pending[7]), 64'(0));

        // Reset while both FIFOs hold entries: nothing stale afterwards.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, AW'($urandom), $urandom, 1'b1, AW'($urandom), $urandom);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("t6_busy_pre", 64'(busy), 64'(1));
        chk("t6_pend_pre", 64'(pending != '0), 64'(1));
        do_reset();
        ws = obs_d.size();
        for (int c = 0; c < 4; c++) cycle();
        chk("t6_no_stale", 64'(obs_d.size() - ws), 64'(0));

        // Random traffic with a narrow address range and occasional resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(63) == 0) do_reset();
            drive(1'($urandom_range(1)), AW'($urandom_range(7)), $urandom,
                  1'($urandom_range(1)), AW'($urandom_range(7)), $urandom);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int c = 0; c < 6; c++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
